// File: rtl/pcie_skp_pkg.sv
// Shared constants, FSM state type and SKP symbol generator for the TX SKP scheduler.
package pcie_skp_pkg;

  localparam logic [7:0] COM_K28_5 = 8'hBC;
  localparam logic [7:0] SKP_K28_0 = 8'h1C;
  localparam logic [7:0] SKP_G3    = 8'hAA;
  localparam logic [7:0] SKP_END   = 8'hE1;

  localparam int SKP_LEN_LO = 4;
  localparam int SKP_LEN_HI = 16;
  localparam int IDX_WIDTH  = $clog2(SKP_LEN_HI);

  typedef enum logic {
    PASS,
    SKP_SEND
  } skp_state_e;

  typedef struct packed {
    logic [7:0] symbol;
    logic       k;
    logic       block_type;
  } skp_sym_t;

  // Symbol idx of an SKP ordered set: 8b/10b COM + 3 SKP, or 128b/130b 12xAA, SKP_END, 3 LFSR bytes.
  function automatic skp_sym_t skp_symbol(input logic                 gen3,
                                          input logic [IDX_WIDTH-1:0] idx,
                                          input logic [23:0]          lfsr);
    skp_sym_t s;
    s = '{symbol: SKP_K28_0, k: 1'b1, block_type: 1'b0};
    if (!gen3) begin
      if (idx == '0) s.symbol = COM_K28_5;
    end else begin
      s.k          = 1'b0;
      s.block_type = 1'b1;
      case (idx)
        4'd12:   s.symbol = SKP_END;
        4'd13:   s.symbol = lfsr[23:16];
        4'd14:   s.symbol = lfsr[15:8];
        4'd15:   s.symbol = lfsr[7:0];
        default: s.symbol = SKP_G3;
      endcase
    end
    return s;
  endfunction

endpackage

// File: rtl/skp_interval_timer.sv
// Symbol-time interval counter and saturating pending-SKP counter.
module skp_interval_timer
  import pcie_skp_pkg::*;
#(
  parameter int SKP_INTERVAL_LO = 1180,
  parameter int SKP_INTERVAL_HI = 5920,
  parameter int CNT_WIDTH       = 13,
  parameter int MAX_PENDING     = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic skp_en,
  input  logic higher_gen_en,
  input  logic skp_done,
  output logic pending_nz
);

  localparam int PEND_WIDTH = $clog2(MAX_PENDING + 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_LO  = CNT_WIDTH'(SKP_INTERVAL_LO - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_HI  = CNT_WIDTH'(SKP_INTERVAL_HI - 1);
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = PEND_WIDTH'(MAX_PENDING);

  logic [CNT_WIDTH-1:0]  count;
  logic [CNT_WIDTH-1:0]  last;
  logic [PEND_WIDTH-1:0] pending;
  logic                  wrap;
  logic                  inc;
  logic                  dec;

  assign last = higher_gen_en ? LAST_HI : LAST_LO;
  // >= so a live Gen3->Gen1 switch with count past LAST_LO wraps at once instead of rolling over.
  assign wrap       = skp_en && (count >= last);
  assign inc        = wrap && (pending != PEND_MAX);
  assign dec        = skp_done && (pending != '0);
  assign pending_nz = (pending != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count   <= '0;
      pending <= '0;
    end else if (clr || !skp_en) begin
      count   <= '0;
      pending <= '0;
    end else begin
      count <= wrap ? '0 : count + 1'b1;
      if (inc && !dec) begin
        pending <= pending + 1'b1;
      end else if (dec && !inc) begin
        pending <= pending - 1'b1;
      end
    end
  end

endmodule

// File: rtl/tx_skp_scheduler.sv
// TX clock-compensation source: stalls upstream at a legal boundary and muxes out SKP ordered sets.
module tx_skp_scheduler
  import pcie_skp_pkg::*;
#(
  parameter int SYMBOL_WIDTH    = 8,
  parameter int SKP_INTERVAL_LO = 1180,
  parameter int SKP_INTERVAL_HI = 5920,
  parameter int CNT_WIDTH       = 13,
  parameter int MAX_PENDING     = 2
) (
  input  logic                    tx_clk,
  input  logic                    tx_rst,
  input  logic                    LTSSM_rst,
  input  logic                    skp_en,
  input  logic                    higher_gen_en,
  input  logic [SYMBOL_WIDTH-1:0] in_symbol,
  input  logic                    in_k,
  input  logic                    in_block_type,
  input  logic                    in_valid,
  input  logic                    in_boundary,
  output logic                    in_ready,
  input  logic [23:0]             skp_lfsr,
  output logic [SYMBOL_WIDTH-1:0] out_symbol,
  output logic                    out_k,
  output logic                    out_block_type,
  output logic                    out_valid,
  output logic                    skp_active
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX_LO = IDX_WIDTH'(SKP_LEN_LO - 1);
  localparam logic [IDX_WIDTH-1:0] LAST_IDX_HI = IDX_WIDTH'(SKP_LEN_HI - 1);

  skp_state_e            state;
  skp_state_e            state_nxt;
  logic [IDX_WIDTH-1:0]  idx;
  logic [IDX_WIDTH-1:0]  idx_nxt;
  logic                  mode;
  logic [23:0]           lfsr_q;
  logic                  pending_nz;
  logic                  start;
  logic                  last_sym;
  logic                  sel_mode;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic                  in_ready_c;
  skp_sym_t              skp_sym;
  logic [SYMBOL_WIDTH-1:0] symbol_d;
  logic                  k_d;
  logic                  block_type_d;
  logic                  valid_d;
  logic                  active_d;

  skp_interval_timer #(
    .SKP_INTERVAL_LO (SKP_INTERVAL_LO),
    .SKP_INTERVAL_HI (SKP_INTERVAL_HI),
    .CNT_WIDTH       (CNT_WIDTH),
    .MAX_PENDING     (MAX_PENDING)
  ) u_timer (
    .clk           (tx_clk),
    .rst_n         (tx_rst),
    .clr           (LTSSM_rst),
    .skp_en        (skp_en),
    .higher_gen_en (higher_gen_en),
    .skp_done      (last_sym),
    .pending_nz    (pending_nz)
  );

  assign start    = (state == PASS) && pending_nz && skp_en && (!in_valid || in_boundary);
  assign last_sym = (state == SKP_SEND) && (idx == (mode ? LAST_IDX_HI : LAST_IDX_LO));

  // The first SKP symbol is emitted on the start edge, before mode/idx are registered.
  assign sel_mode = start ? higher_gen_en : mode;
  assign sel_idx  = start ? '0 : idx;
  assign skp_sym  = skp_symbol(sel_mode, sel_idx, lfsr_q);

  // Held low during reset so upstream never sees a transfer while the block is cleared.
  assign in_ready = tx_rst && in_ready_c;

  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      state  <= PASS;
      idx    <= '0;
      mode   <= 1'b0;
      lfsr_q <= '0;
    end else if (LTSSM_rst) begin
      state  <= PASS;
      idx    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      if (start) begin
        mode   <= higher_gen_en;
        lfsr_q <= skp_lfsr;
      end
    end
  end

  // NOTE: every variable driven in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      PASS: begin
        if (start) begin
          state_nxt = SKP_SEND;
          idx_nxt   = IDX_WIDTH'(1);
        end
      end
      SKP_SEND: begin
        if (last_sym) begin
          state_nxt = PASS;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = PASS;
        idx_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    in_ready_c   = 1'b0;
    symbol_d     = '0;
    k_d          = 1'b0;
    block_type_d = 1'b0;
    valid_d      = 1'b0;
    active_d     = 1'b0;
    if (start || (state == SKP_SEND)) begin
      symbol_d     = SYMBOL_WIDTH'(skp_sym.symbol);
      k_d          = skp_sym.k;
      block_type_d = skp_sym.block_type;
      valid_d      = 1'b1;
      active_d     = 1'b1;
    end else if (state == PASS) begin
      in_ready_c = 1'b1;
      if (in_valid) begin
        symbol_d     = in_symbol;
        k_d          = in_k;
        block_type_d = in_block_type;
        valid_d      = 1'b1;
      end
    end
  end

  always_ff @(posedge tx_clk or negedge tx_rst) begin
    if (!tx_rst) begin
      out_symbol     <= '0;
      out_k          <= 1'b0;
      out_block_type <= 1'b0;
      out_valid      <= 1'b0;
      skp_active     <= 1'b0;
    end else if (LTSSM_rst) begin
      out_symbol     <= '0;
      out_k          <= 1'b0;
      out_block_type <= 1'b0;
      out_valid      <= 1'b0;
      skp_active     <= 1'b0;
    end else begin
      out_symbol     <= symbol_d;
      out_k          <= k_d;
      out_block_type <= block_type_d;
      out_valid      <= valid_d;
      skp_active     <= active_d;
    end
  end

endmodule

// File: tb/tb_tx_skp_scheduler.sv
// Directed bench for tx_skp_scheduler with short intervals (LO=20, HI=40) to keep runs brief.
module tb_tx_skp_scheduler;

  logic        tx_clk;
  logic        tx_rst;
  logic        LTSSM_rst;
  logic        skp_en;
  logic        higher_gen_en;
  logic [7:0]  in_symbol;
  logic        in_k;
  logic        in_block_type;
  logic        in_valid;
  logic        in_boundary;
  logic        in_ready;
  logic [23:0] skp_lfsr;
  logic [7:0]  out_symbol;
  logic        out_k;
  logic        out_block_type;
  logic        out_valid;
  logic        skp_active;

  int checks   = 0;
  int failures = 0;

  tx_skp_scheduler #(
    .SYMBOL_WIDTH    (8),
    .SKP_INTERVAL_LO (20),
    .SKP_INTERVAL_HI (40),
    .CNT_WIDTH       (13),
    .MAX_PENDING     (2)
  ) dut (
    .tx_clk         (tx_clk),
    .tx_rst         (tx_rst),
    .LTSSM_rst      (LTSSM_rst),
    .skp_en         (skp_en),
    .higher_gen_en  (higher_gen_en),
    .in_symbol      (in_symbol),
    .in_k           (in_k),
    .in_block_type  (in_block_type),
    .in_valid       (in_valid),
    .in_boundary    (in_boundary),
    .in_ready       (in_ready),
    .skp_lfsr       (skp_lfsr),
    .out_symbol     (out_symbol),
    .out_k          (out_k),
    .out_block_type (out_block_type),
    .out_valid      (out_valid),
    .skp_active     (skp_active)
  );

  initial tx_clk = 1'b0;
  always #5 tx_clk = ~tx_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge tx_clk);
    #1;
  endtask

  // Ticks until out_valid is seen or the budget is spent; n is the number of edges taken.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < budget);
  endtask

  initial begin
    int          n;
    int          cnt;
    int          bc_cnt;
    int          idx_in;
    int          ready_low;
    int          skp_pos;
    int          first_skp;
    int          mism;
    logic        acc;
    logic [7:0]  exp_g3 [16];
    logic [7:0]  exp_sym;
    logic [7:0]  q [$];

    for (int p = 0; p < 12; p++) exp_g3[p] = 8'hAA;
    exp_g3[12] = 8'hE1;
    exp_g3[13] = 8'h12;
    exp_g3[14] = 8'h34;
    exp_g3[15] = 8'h56;

    tx_rst = 1'b0; LTSSM_rst = 1'b0; skp_en = 1'b0; higher_gen_en = 1'b0;
    in_symbol = 8'h00; in_k = 1'b0; in_block_type = 1'b0; in_valid = 1'b0;
    in_boundary = 1'b0; skp_lfsr = 24'h0;

    // Reset state
    repeat (3) @(posedge tx_clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_symbol", out_symbol, 0);
    check("rst_out_k", out_k, 0);
    check("rst_out_block_type", out_block_type, 0);
    check("rst_skp_active", skp_active, 0);
    check("rst_in_ready", in_ready, 0);
    tx_rst = 1'b1;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    // Gen1/2 idle insertion: first SKP on edge 21, then every 20 edges
    skp_en = 1'b1;
    wait_valid(100, n);
    check("g1_first_skp_edge", n, 21);
    check("g1_com", {out_symbol, out_k, out_block_type, skp_active}, {8'hBC, 1'b1, 1'b0, 1'b1});
    check("g1_in_ready_during_skp", in_ready, 0);
    for (int k = 1; k < 4; k++) begin
      tick();
      check("g1_skp", {out_symbol, out_k, out_block_type, skp_active}, {8'h1C, 1'b1, 1'b0, 1'b1});
    end
    tick();
    check("g1_gap_valid", out_valid, 0);
    wait_valid(100, n);
    check("g1_period", n, 16);
    check("g1_second_com", out_symbol, 8'hBC);

    // LTSSM_rst aborts the SKP in flight; then a plain pass-through transfer
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    check("g1_abort_valid", {out_valid, skp_active}, 2'b00);
    in_valid = 1'b1; in_symbol = 8'h5A; in_k = 1'b1; in_block_type = 1'b1; in_boundary = 1'b0;
    #1;
    check("pass_in_ready", in_ready, 1);
    tick();
    check("pass_data", {out_symbol, out_k, out_block_type, out_valid, skp_active},
          {8'h5A, 1'b1, 1'b1, 1'b1, 1'b0});
    in_valid = 1'b0; in_k = 1'b0; in_block_type = 1'b0;
    tick();
    check("pass_idle_valid", out_valid, 0);

    // Wrap coinciding with the last SKP symbol: pending stays 1, second SKP back-to-back
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    in_valid = 1'b1; in_boundary = 1'b0; in_symbol = 8'h33;
    repeat (36) tick();
    in_boundary = 1'b1;
    #1;
    check("coin_start_in_ready", in_ready, 0);
    tick();
    check("coin_first_com", {out_symbol, skp_active}, {8'hBC, 1'b1});
    repeat (3) tick();
    check("coin_last_skp", {out_symbol, skp_active}, {8'h1C, 1'b1});
    tick();
    check("coin_back_to_back_com", {out_symbol, skp_active}, {8'hBC, 1'b1});
    repeat (3) tick();
    check("coin_second_last", {out_symbol, skp_active}, {8'h1C, 1'b1});
    tick();
    check("coin_resume_data", {out_symbol, out_valid, skp_active}, {8'h33, 1'b1, 1'b0});

    // Pending saturation: three wraps without a boundary give exactly two SKPs
    in_boundary = 1'b0;
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    cnt = 0;
    repeat (65) begin
      tick();
      if (skp_active) cnt++;
    end
    check("sat_no_skp_without_boundary", cnt, 0);
    in_boundary = 1'b1;
    cnt = 0; bc_cnt = 0;
    repeat (14) begin
      tick();
      if (skp_active) cnt++;
      if (skp_active && out_symbol == 8'hBC) bc_cnt++;
    end
    check("sat_skp_cycles", cnt, 8);
    check("sat_com_count", bc_cnt, 2);

    // Gen3 boundary wait with a continuous stream, boundary every 16th symbol
    in_valid = 1'b0; in_boundary = 1'b0; higher_gen_en = 1'b1; skp_lfsr = 24'h123456;
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    idx_in = 0; ready_low = 0; skp_pos = 0; first_skp = 0; mism = 0;
    q.delete();
    for (int t = 1; t <= 75; t++) begin
      in_valid    = 1'b1;
      in_symbol   = 8'(idx_in);
      in_boundary = (idx_in % 16 == 0);
      #1;
      acc = in_ready;
      if (!acc) ready_low++;
      tick();
      if (out_valid && skp_active) begin
        if (skp_pos == 0) first_skp = t;
        exp_sym = (skp_pos < 16) ? exp_g3[skp_pos] : 8'h00;
        check("g3_skp_symbol", {out_symbol, out_k, out_block_type}, {exp_sym, 1'b0, 1'b1});
        skp_pos++;
        if (skp_pos == 1) skp_lfsr = 24'hFFFFFF;
      end else if (out_valid) begin
        q.push_back(out_symbol);
      end
      if (acc) idx_in++;
    end
    check("g3_first_skp_edge", first_skp, 49);
    check("g3_skp_length", skp_pos, 16);
    check("g3_in_ready_low_cycles", ready_low, 16);
    check("g3_stream_count", q.size(), 59);
    for (int k = 0; k < q.size(); k++) begin
      if (q[k] !== 8'(k)) mism++;
    end
    check("g3_stream_order", mism, 0);

    // Gen3 abort by LTSSM_rst at idx=2
    in_valid = 1'b0; in_boundary = 1'b0; skp_lfsr = 24'h123456;
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    wait_valid(100, n);
    check("g3_idle_first_skp_edge", n, 41);
    check("g3_idle_sym0", {out_symbol, out_block_type, skp_active}, {8'hAA, 1'b1, 1'b1});
    tick();
    LTSSM_rst = 1'b1;
    tick();
    LTSSM_rst = 1'b0;
    check("abort_outputs", {out_valid, skp_active, out_symbol, out_block_type}, {1'b0, 1'b0, 8'h00, 1'b0});
    #1;
    check("abort_in_ready", in_ready, 1);
    wait_valid(100, n);
    check("abort_counter_restart", n, 41);

    // Async tx_rst mid-SKP clears outputs without waiting for a clock
    #2;
    tx_rst = 1'b0;
    #1;
    check("async_rst_outputs", {out_valid, skp_active, out_symbol, out_k, out_block_type, in_ready},
          {1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    tick();
    tx_rst = 1'b1;
    higher_gen_en = 1'b0;

    // skp_en drop mid-SKP: the SKP completes, then nothing until re-enabled
    wait_valid(100, n);
    check("en_first_skp_edge", n, 21);
    check("en_com", out_symbol, 8'hBC);
    skp_en = 1'b0;
    for (int k = 1; k < 4; k++) begin
      tick();
      check("en_drop_skp", {out_symbol, out_k, skp_active}, {8'h1C, 1'b1, 1'b1});
    end
    cnt = 0;
    repeat (60) begin
      tick();
      if (out_valid) cnt++;
    end
    check("en_off_no_skp", cnt, 0);
    skp_en = 1'b1;
    wait_valid(100, n);
    check("en_restart_edge", n, 21);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_skp_scheduler.md
Name: tx_skp_scheduler

Overview:
- Transmit-side clock-compensation source for the PCIe 5.0 MAC.
- Counts symbol times and schedules SKP ordered sets. Inserts each SKP at the next legal boundary in the TX symbol stream by stalling upstream and muxing out the SKP sequence.
- Sits between the TX framing/ordered-set mux and the byte striping/scrambler. Supplies the SKPs that the link-partner RX elastic buffer adds or removes.

Parameters:
- SYMBOL_WIDTH, 8, symbol width in bits.
- SKP_INTERVAL_LO, 1180, symbol times between SKP schedules, Gen1/2.
- SKP_INTERVAL_HI, 5920, symbol times between SKP schedules, Gen3+ (370 blocks x 16).
- CNT_WIDTH, 13, interval counter width; must hold SKP_INTERVAL_HI-1.
- MAX_PENDING, 2, saturation limit of the pending-SKP counter.

Ports:
- tx_clk  in  1  TX symbol clock; one symbol per cycle.
- tx_rst  in  1  asynchronous, active-low reset.
- LTSSM_rst  in  1  synchronous clear from LTSSM, active-high.
- skp_en  in  1  scheduling enable.
- higher_gen_en  in  1  1 = Gen3+ 128b/130b SKP format, 0 = Gen1/2 8b/10b format.
- in_symbol  in  SYMBOL_WIDTH  upstream symbol.
- in_k  in  1  upstream K-character flag (Gen1/2).
- in_block_type  in  1  upstream block type: 1 = ordered set, 0 = data.
- in_valid  in  1  upstream symbol valid.
- in_boundary  in  1  in_symbol is the first symbol of a packet/block; SKP may be inserted before it.
- in_ready  out  1  upstream transfer accepted when in_valid && in_ready.
- skp_lfsr  in  24  Gen3+ LFSR snapshot for the last 3 SKP symbols.
- out_symbol  out  SYMBOL_WIDTH  output symbol.
- out_k  out  1  K flag.
- out_block_type  out  1  block type.
- out_valid  out  1  output symbol valid.
- skp_active  out  1  high while SKP symbols are on the output.

Behaviour:
- **Reset** (tx_rst low, async): all outputs 0; FSM = PASS; interval counter = 0; pending = 0.
- **LTSSM_rst**: same clear, synchronous. It has priority over everything, including an in-flight SKP, which is aborted immediately.
- **Interval counter**:
  - While skp_en=1, increments every cycle.
  - At interval-1 it wraps to 0 and pending increments, saturating at MAX_PENDING.
  - Interval = higher_gen_en ? SKP_INTERVAL_HI : SKP_INTERVAL_LO, sampled live.
  - The counter keeps running during SKP transmission.
- **skp_en=0**: counter and pending cleared next cycle. Any in-flight SKP completes untruncated.
- **Pending update**: a simultaneous wrap-increment and SKP-completion decrement leaves pending unchanged.
- **Start condition** (combinational) = state==PASS && pending!=0 && skp_en && (!in_valid || in_boundary).
- **FSM PASS**:
  - in_ready = !start.
  - A transfer registers in_symbol/in_k/in_block_type to the outputs with out_valid=1; latency 1 cycle.
  - With no transfer, out_valid=0.
  - On start: latch mode (higher_gen_en), idx=0, go to SKP_SEND. The SKP begins on the outputs on the same cycle edge, so there is no bubble.
- **FSM SKP_SEND**:
  - in_ready=0; out_valid=1; skp_active=1; idx increments.
  - Gen1/2 (4 symbols): COM 0xBC k=1, then SKP 0x1C k=1 three times; out_block_type=0.
  - Gen3+ (16 symbols): 0xAA x12, SKP_END 0xE1, skp_lfsr[23:16], [15:8], [7:0]; out_k=0; out_block_type=1 on all 16.
  - skp_lfsr is captured at SKP start.
  - On the last symbol: pending decrements and the FSM returns to PASS. If pending is still nonzero and the start condition holds, a back-to-back SKP starts.
- **Mode change**: higher_gen_en changing mid-SKP is ignored; the latched mode is used.
- **Upstream hold**: upstream must hold in_symbol stable while in_ready=0. No symbol is lost or duplicated.
- **No downstream backpressure**: the serializer consumes every cycle.

Decomposition:
- **Package pcie_skp_pkg**:
  - Constants: COM_K28_5=8'hBC, SKP_K28_0=8'h1C, SKP_G3=8'hAA, SKP_END=8'hE1, SKP_LEN_LO=4, SKP_LEN_HI=16.
  - FSM state enum {PASS, SKP_SEND}.
- **Sub-module skp_interval_timer**: interval counter plus pending counter; outputs pending_nz; input skp_done.
- **Top** holds the FSM, output mux and the registered output stage.

Test Plan:
- **Gen1/2 idle insertion**: INTERVAL_LO=20, skp_en=1, in_valid=0 → at cycle 20 the next 4 outputs are BC/1C/1C/1C with k=1 and skp_active=1, repeating every 20 cycles.
- **Gen3 boundary wait**: INTERVAL_HI=40, continuous in_valid, in_boundary only every 16th symbol, skp_lfsr=24'h123456 → SKP is deferred to the next boundary. Output is AA x12, E1, 12, 34, 56 with block_type=1. in_ready=0 for exactly 16 cycles. The upstream stream resumes with no loss (compare in/out sequences).
- **Pending saturation**: in_boundary=0 with in_valid=1 for 3 intervals → pending=2. Then in_boundary=1 → exactly 2 back-to-back SKPs.
- **Simultaneous increment/decrement**: a wrap coinciding with the last SKP symbol → pending stays 1 and a second SKP follows immediately.
- **Abort**: LTSSM_rst at idx=2 of a Gen3 SKP → next cycle out_valid=0, pending=0, counter=0, in_ready=1. Async tx_rst mid-SKP → all outputs 0 immediately.
- **skp_en drop mid-SKP**: the SKP completes all 4 symbols, after which pending=0 and the counter is held at 0 with no further SKPs.
